iddrx2_dqsa_rx: RTL and testbench
=================================

# iddrx2_dqsa_rx

Behavioural simulation model of the ECP3 x2 DDR read-capture path, the receive-side counterpart of the DQS-strobed DDR output register. It samples the DQ pad on both edges of the edge clock and runs a read-window state machine that waits a programmable read latency. Each burst is deserialized into 4-beat words on a 1:4 gearbox, with a one-cycle valid strobe per word. It sits between the DQ input buffer and the memory-controller read datapath.

## Interface
- BURST_LEN, 8: beats per read burst; legal values 4, 8, 16. N = BURST_LEN/2 capture edges per burst.
- READ_LAT, 2: ECLK rising edges from RDEN acceptance to the first capture edge; legal values 1..15.
- ECLK  in  1  edge clock. Beats are captured on both edges; all state changes on the rising edge.
- RSTN  in  1  reset, asynchronous and active-low.
- D  in  1  DQ pad data, one beat per ECLK half-cycle.
- RDEN  in  1  read-window request from the controller, sampled on ECLK rise.
- Q0, Q1, Q2, Q3  out  1 each  deserialized word; Q0 is the oldest beat, Q3 the newest.
- DVALID  out  1  one-cycle pulse marking a new word on Q0..Q3.
- BUSY  out  1  burst in progress; RDEN is not accepted while high.
- ERR  out  1  one-cycle pulse: RDEN was asserted while BUSY.

## Operation
- FSM states:
  - IDLE: BUSY=0.
  - PRE: latency countdown, READ_LAT-1 cycles.
  - DATA: N capture edges.
- IDLE -> PRE on an edge with RDEN=1, or IDLE -> DATA directly when READ_LAT=1.
- PRE -> DATA when the latency counter expires.
- DATA -> IDLE after capture edge r_{N-1}.
- Capture edges: acceptance at rising edge t gives r_c = t + READ_LAT + c, for c = 0..N-1.
- Beat 2c is sampled from D at rising edge r_c. Beat 2c+1 is sampled at the following falling edge, then retimed to the next rising edge.
- Word w holds beats 4w..4w+3, in order, on Q0..Q3.
- Word w is loaded at rising edge r_{2w+2}. DVALID is high for exactly that cycle.
- The last word loads at edge t+READ_LAT+N, after BUSY has fallen. The output gearbox runs independently of FSM state.
- Q0..Q3 hold their value between DVALID pulses.
- RDEN=1 at an edge where BUSY was already 1 is ignored. ERR pulses high for the next cycle and the burst in flight is unaffected.
- D=X at a capture edge propagates X to the corresponding Q bit of that word only.
- RSTN low, asynchronous, at any time:
  - State goes to IDLE and all counters clear.
  - Q0..Q3, DVALID, BUSY and ERR go to 0.
  - The rise, fall and partial-word registers clear, so a partially captured word is discarded.
  - RSTN release takes effect at the first rising edge after it.
- Reset values: Q0..Q3=0, DVALID=0, BUSY=0, ERR=0.

## Timing
- BUSY rises at edge t and falls at edge r_{N-1} = t+READ_LAT+N-1.
- Earliest next accepted RDEN edge is t+READ_LAT+N. Its r_0 is at or after t+2·READ_LAT+N, so consecutive bursts never overlap in the gearbox.
- Latency from acceptance edge to first DVALID: READ_LAT+2 rising edges.
- DVALID spacing within a burst: 2 ECLK cycles. N/2 DVALID pulses per burst.
- Back-to-back bursts (RDEN at edge t+READ_LAT+N): the first burst's last word and the second burst's capture coexist without corruption.

## Test plan
- Basic burst: BURST_LEN=8, READ_LAT=2, RDEN=1 at edge 10, D beats 1,0,1,1,0,0,1,0 from edge 12 -> Q0..Q3=1,0,1,1 with DVALID at edge 14; Q0..Q3=0,0,1,0 with DVALID at edge 16; BUSY high after edge 10, low after edge 15.
- Illegal request: same burst plus RDEN=1 at edge 13 -> ERR=1 for the cycle after edge 13 only; output words identical to the basic burst.
- Back-to-back: second RDEN at edge 16 with beats 0,1,1,1,1,0,0,0 -> words 0,1,1,1 at edge 20 and 1,0,0,0 at edge 22; first burst's edge-16 word is intact; ERR never asserts.
- Latency and length sweep: READ_LAT=1 and 15, BURST_LEN=4 and 16 -> first DVALID at t+READ_LAT+2; N/2 pulses per burst; beat order preserved.
- Reset mid-burst: RSTN low between edges 14 and 15 of the basic burst -> all outputs 0 immediately; no DVALID at edge 16; a fresh RDEN after release produces a clean burst.
- X propagation: D=X on beat 5 only -> second word Q1=X, all other bits correct.

Source files
------------

// File: rtl/iddrx2_dqsa_rx_if.sv
// DQ read-capture bundle between the pad-side driver and the x2 read-capture block.
// The master side drives pad data and read requests; the slave side returns deserialized words.
interface iddrx2_dqsa_rx_if;
    logic D;
    logic RDEN;
    logic Q0;
    logic Q1;
    logic Q2;
    logic Q3;
    logic DVALID;
    logic BUSY;
    logic ERR;

    modport master (output D, RDEN, input Q0, Q1, Q2, Q3, DVALID, BUSY, ERR);
    modport slave  (input D, RDEN, output Q0, Q1, Q2, Q3, DVALID, BUSY, ERR);
endinterface

// File: rtl/iddrx2_dqsa_rx.sv
// x2 DDR read capture with 1:4 gearbox; first word READ_LAT+2 ECLK rises after RDEN acceptance.
// No backpressure: RDEN while BUSY is dropped and flagged on ERR; words are emitted unconditionally.
module iddrx2_dqsa_rx #(
    parameter int BURST_LEN = 8,
    parameter int READ_LAT  = 2
) (
    input  logic              ECLK,
    input  logic              RSTN,
    iddrx2_dqsa_rx_if.slave   rx
);
    localparam int          N        = BURST_LEN / 2;
    localparam logic [3:0]  LAT_LOAD = (READ_LAT > 1) ? 4'(READ_LAT - 2) : 4'd0;
    localparam logic [3:0]  CAP_LAST = 4'(N - 1);

    typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;

    state_t      state, state_nxt;
    logic [3:0]  lat_cnt, lat_cnt_nxt;
    logic [3:0]  cap_cnt, cap_cnt_nxt;
    logic        busy;
    logic        err_q;

    logic        rise_q;
    logic        fall_q;
    logic        cap_vld;
    logic        phase;
    logic [1:0]  part;
    logic [3:0]  word;
    logic        dvalid_q;

    assign busy = (state != IDLE);

    always_ff @(posedge ECLK or negedge RSTN) begin
        if (!RSTN) begin
            state   <= IDLE;
            lat_cnt <= '0;
            cap_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
            cap_cnt <= cap_cnt_nxt;
            err_q   <= rx.RDEN && busy;
        end
    end

    always_comb begin
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        cap_cnt_nxt = cap_cnt;
        case (state)
            IDLE: begin
                if (rx.RDEN) begin
                    cap_cnt_nxt = '0;
                    if (READ_LAT == 1) begin
                        state_nxt = DATA;
                    end else begin
                        state_nxt   = PRE;
                        lat_cnt_nxt = LAT_LOAD;
                    end
                end
            end
            PRE: begin
                if (lat_cnt == 4'd0) state_nxt = DATA;
                else                 lat_cnt_nxt = lat_cnt - 4'd1;
            end
            DATA: begin
                if (cap_cnt == CAP_LAST) begin
                    state_nxt   = IDLE;
                    cap_cnt_nxt = '0;
                end else begin
                    cap_cnt_nxt = cap_cnt + 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Odd beats land on the falling edge and are only consumed at the next rise.
    always_ff @(negedge ECLK or negedge RSTN) begin
        if (!RSTN) fall_q <= 1'b0;
        else       fall_q <= rx.D;
    end

    // A rise/fall pair completes one rising edge after its capture edge; two pairs make a word.
    always_ff @(posedge ECLK or negedge RSTN) begin
        if (!RSTN) begin
            rise_q   <= 1'b0;
            cap_vld  <= 1'b0;
            phase    <= 1'b0;
            part     <= '0;
            word     <= '0;
            dvalid_q <= 1'b0;
        end else begin
            cap_vld  <= (state == DATA);
            dvalid_q <= 1'b0;
            if (state == DATA) rise_q <= rx.D;
            if (cap_vld) begin
                phase <= ~phase;
                if (!phase) begin
                    part <= {rise_q, fall_q};
                end else begin
                    word     <= {part, rise_q, fall_q};
                    dvalid_q <= 1'b1;
                end
            end
        end
    end

    assign rx.Q0     = word[3];
    assign rx.Q1     = word[2];
    assign rx.Q2     = word[1];
    assign rx.Q3     = word[0];
    assign rx.DVALID = dvalid_q;
    assign rx.BUSY   = busy;
    assign rx.ERR    = err_q;
endmodule

// File: tb/tb_iddrx2_dqsa_rx.sv
// Directed bench for the x2 read-capture block: basic, illegal request, back-to-back,
// mid-burst reset, X beat, and latency/length sweep on three parameterisations.
module tb_iddrx2_dqsa_rx;
    logic       eclk;
    logic       rstn;
    logic       d;
    logic [2:0] rden;

    iddrx2_dqsa_rx_if if0();
    iddrx2_dqsa_rx_if if1();
    iddrx2_dqsa_rx_if if2();

    iddrx2_dqsa_rx #(.BURST_LEN(8),  .READ_LAT(2))  dut0 (.ECLK(eclk), .RSTN(rstn), .rx(if0));
    iddrx2_dqsa_rx #(.BURST_LEN(4),  .READ_LAT(1))  dut1 (.ECLK(eclk), .RSTN(rstn), .rx(if1));
    iddrx2_dqsa_rx #(.BURST_LEN(16), .READ_LAT(15)) dut2 (.ECLK(eclk), .RSTN(rstn), .rx(if2));

    assign if0.D = d;  assign if0.RDEN = rden[0];
    assign if1.D = d;  assign if1.RDEN = rden[1];
    assign if2.D = d;  assign if2.RDEN = rden[2];

    logic       dv [3];
    logic       bz [3];
    logic       er [3];
    logic [3:0] qw [3];

    assign dv[0] = if0.DVALID; assign bz[0] = if0.BUSY; assign er[0] = if0.ERR;
    assign dv[1] = if1.DVALID; assign bz[1] = if1.BUSY; assign er[1] = if1.ERR;
    assign dv[2] = if2.DVALID; assign bz[2] = if2.BUSY; assign er[2] = if2.ERR;
    assign qw[0] = {if0.Q0, if0.Q1, if0.Q2, if0.Q3};
    assign qw[1] = {if1.Q0, if1.Q1, if1.Q2, if1.Q3};
    assign qw[2] = {if2.Q0, if2.Q1, if2.Q2, if2.Q3};

    initial eclk = 1'b0;
    always #5 eclk = ~eclk;

    int checks = 0;
    int errors = 0;

    logic [3:0] got_w [$];
    int         got_e [$];
    int         err_e [$];
    int         busy_on;
    int         busy_off;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Rising-edge beat is set before the rise, falling-edge beat right after it;
    // returns 1 time unit after the rise so outputs reflect that edge.
    task automatic tick(input logic [2:0] r, input logic dr, input logic df);
        @(negedge eclk);
        #1;
        rden = r;
        d    = dr;
        @(posedge eclk);
        #1;
        d = df;
    endtask

    // Edge 0 is the acceptance edge; optional second burst at t2, stray RDEN at err_at,
    // X on beat xbeat of the first burst, reset pulse right after edge rst_at.
    task automatic run(input int idx, input int rl, input int n, input logic [15:0] bt1,
                       input int t2, input logic [15:0] bt2, input int err_at,
                       input int xbeat, input int rst_at, input int len);
        got_w.delete();
        got_e.delete();
        err_e.delete();
        busy_on  = -1;
        busy_off = -1;
        for (int e = 0; e < len; e++) begin
            logic [2:0] r;
            logic       dr;
            logic       df;
            int         c;
            r  = '0;
            dr = 1'b0;
            df = 1'b0;
            if (e == 0 || e == t2 || e == err_at) r[idx] = 1'b1;
            c = e - rl;
            if (c >= 0 && c < n) begin
                dr = bt1[15 - 2*c];
                df = bt1[14 - 2*c];
                if (2*c == xbeat)     dr = 1'bx;
                if (2*c + 1 == xbeat) df = 1'bx;
            end
            c = e - t2 - rl;
            if (t2 >= 0 && c >= 0 && c < n) begin
                dr = bt2[15 - 2*c];
                df = bt2[14 - 2*c];
            end
            tick(r, dr, df);
            if (dv[idx]) begin
                got_w.push_back(qw[idx]);
                got_e.push_back(e);
            end
            if (er[idx]) err_e.push_back(e);
            if (bz[idx] && busy_on < 0) busy_on = e;
            if (!bz[idx] && busy_on >= 0 && busy_off < 0) busy_off = e;
            if (e == rst_at) begin
                rstn = 1'b0;
                #1;
                chk("rst_mid_q",    32'(qw[idx]), 32'h0);
                chk("rst_mid_dv",   32'(dv[idx]), 32'h0);
                chk("rst_mid_busy", 32'(bz[idx]), 32'h0);
                chk("rst_mid_err",  32'(er[idx]), 32'h0);
                #2;
                rstn = 1'b1;
            end
        end
    endtask

    localparam logic [15:0] BT_A = 16'b1011_0010_0000_0000;
    localparam logic [15:0] BT_B = 16'b0111_1000_0000_0000;

    initial begin
        rstn = 1'b0;
        d    = 1'b0;
        rden = '0;
        repeat (3) tick(3'b000, 1'b0, 1'b0);
        chk("reset_q",    32'(qw[0]), 32'h0);
        chk("reset_dv",   32'(dv[0]), 32'h0);
        chk("reset_busy", 32'(bz[0]), 32'h0);
        chk("reset_err",  32'(er[0]), 32'h0);
        rstn = 1'b1;
        repeat (3) tick(3'b000, 1'b0, 1'b0);

        // basic burst: words at edges 4 and 6 after acceptance
        run(0, 2, 4, BT_A, -1, 16'h0, -1, -1, -1, 10);
        chk("basic_cnt",   32'(got_w.size()), 32'd2);
        chk("basic_e0",    32'(got_e[0]), 32'd4);
        chk("basic_w0",    32'(got_w[0]), 32'hb);
        chk("basic_e1",    32'(got_e[1]), 32'd6);
        chk("basic_w1",    32'(got_w[1]), 32'h2);
        chk("basic_bon",   32'(busy_on), 32'd0);
        chk("basic_boff",  32'(busy_off), 32'd5);
        chk("basic_noerr", 32'(err_e.size()), 32'd0);
        chk("basic_hold",  32'(qw[0]), 32'h2);

        // stray RDEN while busy
        run(0, 2, 4, BT_A, -1, 16'h0, 3, -1, -1, 10);
        chk("ill_errcnt", 32'(err_e.size()), 32'd1);
        chk("ill_erre",   32'(err_e[0]), 32'd3);
        chk("ill_cnt",    32'(got_w.size()), 32'd2);
        chk("ill_w0",     32'(got_w[0]), 32'hb);
        chk("ill_w1",     32'(got_w[1]), 32'h2);
        chk("ill_boff",   32'(busy_off), 32'd5);

        // back-to-back: second RDEN at the first legal edge
        run(0, 2, 4, BT_A, 6, BT_B, -1, -1, -1, 14);
        chk("b2b_cnt",   32'(got_w.size()), 32'd4);
        chk("b2b_w1",    32'(got_w[1]), 32'h2);
        chk("b2b_e1",    32'(got_e[1]), 32'd6);
        chk("b2b_e2",    32'(got_e[2]), 32'd10);
        chk("b2b_w2",    32'(got_w[2]), 32'h7);
        chk("b2b_e3",    32'(got_e[3]), 32'd12);
        chk("b2b_w3",    32'(got_w[3]), 32'h8);
        chk("b2b_noerr", 32'(err_e.size()), 32'd0);

        // reset right after the first word, then a clean burst
        run(0, 2, 4, BT_A, -1, 16'h0, -1, -1, 4, 10);
        chk("rst_cnt", 32'(got_w.size()), 32'd1);
        chk("rst_w0",  32'(got_w[0]), 32'hb);
        run(0, 2, 4, BT_B, -1, 16'h0, -1, -1, -1, 10);
        chk("post_cnt", 32'(got_w.size()), 32'd2);
        chk("post_e0",  32'(got_e[0]), 32'd4);
        chk("post_w0",  32'(got_w[0]), 32'h7);
        chk("post_w1",  32'(got_w[1]), 32'h8);

        // unknown on beat 5 only touches Q1 of the second word
        run(0, 2, 4, BT_A, -1, 16'h0, -1, 5, -1, 10);
        chk("x_cnt", 32'(got_w.size()), 32'd2);
        chk("x_w0",  32'(got_w[0]), 32'hb);
        chk("x_w1k", 32'(got_w[1] & 4'b1011), 32'h2);

        // BURST_LEN=4, READ_LAT=1
        run(1, 1, 2, 16'b1101_0000_0000_0000, -1, 16'h0, -1, -1, -1, 8);
        chk("s1_cnt",  32'(got_w.size()), 32'd1);
        chk("s1_e0",   32'(got_e[0]), 32'd3);
        chk("s1_w0",   32'(got_w[0]), 32'hd);
        chk("s1_boff", 32'(busy_off), 32'd2);

        // BURST_LEN=16, READ_LAT=15
        run(2, 15, 8, 16'b1000_0110_1101_0011, -1, 16'h0, -1, -1, -1, 28);
        chk("s2_cnt",  32'(got_w.size()), 32'd4);
        chk("s2_e0",   32'(got_e[0]), 32'd17);
        chk("s2_w0",   32'(got_w[0]), 32'h8);
        chk("s2_w1",   32'(got_w[1]), 32'h6);
        chk("s2_w2",   32'(got_w[2]), 32'hd);
        chk("s2_w3",   32'(got_w[3]), 32'h3);
        chk("s2_e3",   32'(got_e[3]), 32'd23);
        chk("s2_boff", 32'(busy_off), 32'd22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
